// File: rtl/udp_rx_stream.sv
// udp_rx_stream: cut-through UDP receive stage that strips the 8-byte header,
// filters on destination port, checks the length field and forwards flushes.
// Ports:
//   clk, nreset                 clock, synchronous active-low reset
//   valid_i/last_i/data_i/keep_i  IPv4 payload beat stream (byte n at data_i[8n+7:8n])
//   flush_i                     MAC CRC failure for the current frame
//   cfg_port_i                  accepted destination port
//   valid_o/last_o/data_o/keep_o  UDP payload beat stream, zero latency
//   err_o                       length mismatch, qualified by valid_o & last_o
//   flush_o                     flush forwarded for an accepted datagram
//   src_port_o/dst_port_o/len_o header fields, valid while hdr_valid_o
//   hdr_valid_o                 high while payload of an accepted datagram flows
module udp_rx_stream #(
   parameter int DATA_W      = 32,
   parameter int KEEP_W      = DATA_W / 8,
   parameter int PORT_FILTER = 1,
   parameter int CHECK_LEN   = 1
) (
   input  logic              clk,
   input  logic              nreset,
   input  logic              valid_i,
   input  logic              last_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [KEEP_W-1:0] keep_i,
   input  logic              flush_i,
   input  logic [15:0]       cfg_port_i,
   output logic              valid_o,
   output logic              last_o,
   output logic [DATA_W-1:0] data_o,
   output logic [KEEP_W-1:0] keep_o,
   output logic              err_o,
   output logic              flush_o,
   output logic [15:0]       src_port_o,
   output logic [15:0]       dst_port_o,
   output logic [15:0]       len_o,
   output logic              hdr_valid_o
);
   typedef enum logic [1:0] {IDLE, HDR1, PLOAD, DISCARD} state_t;
   state_t      state_q, state_d;
   logic [15:0] src_q, src_d, dst_q, dst_d, len_q, len_d, cnt_q, cnt_d;
   logic [15:0] pop, sum_sat, len_hdr;
   logic [16:0] sum;
   logic        pl;
   // The length field sits in bytes 4-5: the low half of the second beat on a
   // 32-bit path, bits [47:32] of the single header beat on a 64-bit path.
   assign len_hdr = {data_i[DATA_W-25 -: 8], data_i[DATA_W-17 -: 8]};
   always_comb begin
      pop = '0;
      for (int i = 0; i < KEEP_W; i++) pop = pop + 16'(keep_i[i]);
   end
   assign sum     = {1'b0, cnt_q} + {1'b0, pop};
   assign sum_sat = sum[16] ? 16'hFFFF : sum[15:0];
   always_comb begin
      state_d = state_q;
      src_d   = src_q;
      dst_d   = dst_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: if (valid_i) begin
            src_d = {data_i[7:0], data_i[15:8]};
            dst_d = {data_i[23:16], data_i[31:24]};
            cnt_d = 16'(KEEP_W);
            if (DATA_W == 32) state_d = last_i ? IDLE : HDR1;
            else begin
               len_d   = len_hdr;
               state_d = last_i ? IDLE : (PORT_FILTER != 0 && dst_d != cfg_port_i) ? DISCARD : PLOAD;
            end
         end
         HDR1: if (flush_i) state_d = IDLE;
            else if (valid_i) begin
               len_d   = len_hdr;
               cnt_d   = 16'd8;
               state_d = last_i ? IDLE : (PORT_FILTER != 0 && dst_q != cfg_port_i) ? DISCARD : PLOAD;
            end
         PLOAD: begin
            if (valid_i) cnt_d = sum_sat;
            if (flush_i || (valid_i && last_i)) state_d = IDLE;
         end
         DISCARD: if (flush_i || (valid_i && last_i)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
      end
   end
   assign pl          = state_q == PLOAD;
   assign valid_o     = pl & valid_i;
   assign last_o      = pl & last_i;
   assign data_o      = data_i;
   assign keep_o      = keep_i;
   assign flush_o     = pl & flush_i;
   assign err_o       = (CHECK_LEN != 0) && valid_o && last_o && (sum_sat != len_q);
   assign hdr_valid_o = pl;
   assign src_port_o  = src_q;
   assign dst_port_o  = dst_q;
   assign len_o       = len_q;
endmodule

// File: tb/tb_udp_rx_stream.sv
// tb_udp_rx_stream: scoreboard bench for a 32-bit filtering and a 64-bit open udp_rx_stream.
module tb_udp_rx_stream;
   typedef struct packed {
      logic        last;
      logic [7:0]  keep;
      logic        err;
      logic        flush;
      logic        hv;
      logic [15:0] src;
      logic [15:0] dst;
      logic [15:0] len;
      logic [63:0] data;
   } beat_t;

   logic        clk = 0, nreset = 0;
   logic        va = 0, la = 0, fa = 0;
   logic [31:0] da = '0;
   logic [3:0]  ka = '0;
   logic        vb = 0, lb = 0, fb = 0;
   logic [63:0] db = '0;
   logic [7:0]  kb = '0;
   logic [15:0] cfg = 16'h1234;
   logic        va_o, la_o, ea_o, fa_o, hva_o;
   logic [31:0] da_o;
   logic [3:0]  ka_o;
   logic [15:0] sa_o, dsa_o, lna_o;
   logic        vb_o, lb_o, eb_o, fb_o, hvb_o;
   logic [63:0] db_o;
   logic [7:0]  kb_o;
   logic [15:0] sb_o, dsb_o, lnb_o;
   beat_t       q32[$], q64[$];
   int          n_cmp = 0, n_bad = 0;

   always #5 clk = ~clk;

   udp_rx_stream #(.DATA_W(32), .PORT_FILTER(1), .CHECK_LEN(1)) u32 (
      .clk(clk), .nreset(nreset), .valid_i(va), .last_i(la), .data_i(da), .keep_i(ka),
      .flush_i(fa), .cfg_port_i(cfg), .valid_o(va_o), .last_o(la_o), .data_o(da_o),
      .keep_o(ka_o), .err_o(ea_o), .flush_o(fa_o), .src_port_o(sa_o), .dst_port_o(dsa_o),
      .len_o(lna_o), .hdr_valid_o(hva_o));

   udp_rx_stream #(.DATA_W(64), .PORT_FILTER(0), .CHECK_LEN(1)) u64 (
      .clk(clk), .nreset(nreset), .valid_i(vb), .last_i(lb), .data_i(db), .keep_i(kb),
      .flush_i(fb), .cfg_port_i(cfg), .valid_o(vb_o), .last_o(lb_o), .data_o(db_o),
      .keep_o(kb_o), .err_o(eb_o), .flush_o(fb_o), .src_port_o(sb_o), .dst_port_o(dsb_o),
      .len_o(lnb_o), .hdr_valid_o(hvb_o));

   function automatic logic [31:0] hdr32a(input logic [15:0] s, input logic [15:0] d);
      return {d[7:0], d[15:8], s[7:0], s[15:8]};
   endfunction
   function automatic logic [31:0] hdr32b(input logic [15:0] l);
      return {16'h0, l[7:0], l[15:8]};
   endfunction
   function automatic logic [63:0] hdr64(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
      return {16'h0, l[7:0], l[15:8], d[7:0], d[15:8], s[7:0], s[15:8]};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic b32(input logic l, input logic [31:0] d, input logic [3:0] k, input logic f);
      va = 1; la = l; da = d; ka = k; fa = f;
      cyc();
      va = 0; la = 0; fa = 0;
   endtask
   task automatic b64(input logic l, input logic [63:0] d, input logic [7:0] k, input logic f);
      vb = 1; lb = l; db = d; kb = k; fb = f;
      cyc();
      vb = 0; lb = 0; fb = 0;
   endtask
   task automatic px(input bit wide, input logic l, input logic [63:0] d, input logic [7:0] k,
                     input logic e, input logic f, input logic [15:0] s, input logic [15:0] ds,
                     input logic [15:0] ln);
      beat_t b;
      b = '{last: l, keep: k, err: e, flush: f, hv: 1'b1, src: s, dst: ds, len: ln, data: d};
      if (wide) q64.push_back(b);
      else q32.push_back(b);
   endtask
   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      n_cmp++;
      if (a !== e) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", n, a, e);
      end
   endtask

   always @(negedge clk) begin
      beat_t act, exp;
      if (va_o === 1'b1 || fa_o === 1'b1) begin
         act = '{last: la_o, keep: 8'(ka_o), err: ea_o, flush: fa_o, hv: hva_o,
                 src: sa_o, dst: dsa_o, len: lna_o, data: 64'(da_o)};
         n_cmp++;
         if (q32.size() == 0) begin
            n_bad++;
            $display("FAIL mon32 unexpected beat: got %h want none", act);
         end else begin
            exp = q32.pop_front();
            if (act !== exp) begin
               n_bad++;
               $display("FAIL mon32 beat: got %h want %h", act, exp);
            end
         end
      end
   end

   always @(negedge clk) begin
      beat_t act, exp;
      if (vb_o === 1'b1 || fb_o === 1'b1) begin
         act = '{last: lb_o, keep: kb_o, err: eb_o, flush: fb_o, hv: hvb_o,
                 src: sb_o, dst: dsb_o, len: lnb_o, data: db_o};
         n_cmp++;
         if (q64.size() == 0) begin
            n_bad++;
            $display("FAIL mon64 unexpected beat: got %h want none", act);
         end else begin
            exp = q64.pop_front();
            if (act !== exp) begin
               n_bad++;
               $display("FAIL mon64 beat: got %h want %h", act, exp);
            end
         end
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid32", 64'(va_o), 0);
      chk("rst_hv32", 64'(hva_o), 0);
      chk("rst_hdr32", {16'h0, sa_o, dsa_o, lna_o}, 0);
      chk("rst_valid64", 64'(vb_o), 0);
      chk("rst_hv64", 64'(hvb_o), 0);
      chk("rst_hdr64", {16'h0, sb_o, dsb_o, lnb_o}, 0);
      nreset = 1;
      cyc();
      // 32-bit: 20-byte datagram, length matches
      b32(0, hdr32a(16'hABCD, 16'h1234), 4'hF, 0);
      b32(0, hdr32b(16'h0014), 4'hF, 0);
      px(0, 0, 64'h11223344, 8'hF, 0, 0, 16'hABCD, 16'h1234, 16'h0014);
      b32(0, 32'h11223344, 4'hF, 0);
      px(0, 0, 64'h55667788, 8'hF, 0, 0, 16'hABCD, 16'h1234, 16'h0014);
      b32(0, 32'h55667788, 4'hF, 0);
      px(0, 1, 64'h99AABBCC, 8'hF, 0, 0, 16'hABCD, 16'h1234, 16'h0014);
      b32(1, 32'h99AABBCC, 4'hF, 0);
      // filtered datagram, then back-to-back accepted one
      b32(0, hdr32a(16'h0001, 16'h0050), 4'hF, 0);
      b32(0, hdr32b(16'h0010), 4'hF, 0);
      b32(0, 32'hDEADBEEF, 4'hF, 0);
      b32(1, 32'hCAFEF00D, 4'hF, 0);
      b32(0, hdr32a(16'h0002, 16'h1234), 4'hF, 0);
      b32(0, hdr32b(16'h000A), 4'hF, 0);
      px(0, 1, 64'h0000A5A5, 8'h3, 0, 0, 16'h0002, 16'h1234, 16'h000A);
      b32(1, 32'h0000A5A5, 4'h3, 0);
      // flush on 2nd payload beat
      b32(0, hdr32a(16'h0003, 16'h1234), 4'hF, 0);
      b32(0, hdr32b(16'h0018), 4'hF, 0);
      px(0, 0, 64'h01010101, 8'hF, 0, 0, 16'h0003, 16'h1234, 16'h0018);
      b32(0, 32'h01010101, 4'hF, 0);
      px(0, 0, 64'h02020202, 8'hF, 0, 1, 16'h0003, 16'h1234, 16'h0018);
      b32(0, 32'h02020202, 4'hF, 1);
      chk("flush_idle_hv", 64'(hva_o), 0);
      cyc();
      // header-only datagram, then short-by-one datagram
      b32(0, hdr32a(16'h0004, 16'h1234), 4'hF, 0);
      b32(1, hdr32b(16'h0008), 4'hF, 0);
      chk("hdronly_hv", 64'(hva_o), 0);
      b32(0, hdr32a(16'h0005, 16'h1234), 4'hF, 0);
      b32(0, hdr32b(16'h000C), 4'hF, 0);
      px(0, 1, 64'h00C0FFEE, 8'h7, 1, 0, 16'h0005, 16'h1234, 16'h000C);
      b32(1, 32'h00C0FFEE, 4'h7, 0);
      // reset during payload
      b32(0, hdr32a(16'h0006, 16'h1234), 4'hF, 0);
      b32(0, hdr32b(16'h0010), 4'hF, 0);
      px(0, 0, 64'h0A0B0C0D, 8'hF, 0, 0, 16'h0006, 16'h1234, 16'h0010);
      b32(0, 32'h0A0B0C0D, 4'hF, 0);
      chk("pre_rst_hv", 64'(hva_o), 1);
      nreset = 0;
      cyc();
      va = 1; la = 1; fa = 1; da = 32'h12345678; ka = 4'hF;
      #1;
      chk("midrst_valid", 64'(va_o), 0);
      chk("midrst_flush", 64'(fa_o), 0);
      chk("midrst_hv", 64'(hva_o), 0);
      chk("midrst_last_err", {62'h0, la_o, ea_o}, 0);
      chk("midrst_hdr", {16'h0, sa_o, dsa_o, lna_o}, 0);
      cyc();
      nreset = 1; va = 0; la = 0; fa = 0;
      cyc();
      // 64-bit: length 16 but 19 bytes received
      b64(0, hdr64(16'hC001, 16'h0050, 16'h0010), 8'hFF, 0);
      px(1, 0, 64'h0102030405060708, 8'hFF, 0, 0, 16'hC001, 16'h0050, 16'h0010);
      b64(0, 64'h0102030405060708, 8'hFF, 0);
      px(1, 1, 64'h0000000000AABBCC, 8'h07, 1, 0, 16'hC001, 16'h0050, 16'h0010);
      b64(1, 64'h0000000000AABBCC, 8'h07, 0);
      b64(0, hdr64(16'hC002, 16'h0060, 16'h000D), 8'hFF, 0);
      px(1, 1, 64'h000000EEDDCCBBAA, 8'h1F, 0, 0, 16'hC002, 16'h0060, 16'h000D);
      b64(1, 64'h000000EEDDCCBBAA, 8'h1F, 0);
      b64(1, hdr64(16'hC003, 16'h0060, 16'h0008), 8'hFF, 0);
      chk("hdronly64_hv", 64'(hvb_o), 0);
      chk("hdronly64_len", 64'(lnb_o), 64'h0008);
      repeat (3) cyc();
      chk("q32_drained", 64'(q32.size()), 0);
      chk("q64_drained", 64'(q64.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
